serial_receiver: RTL and testbench

- Serial UART-style receiver. It is the downstream stage of the serial transmitter: it consumes the txd line (start bit, D data bits LSB first, stop bit) and recovers parallel data.
- Oversamples the line, validates start/stop bits and presents each byte with a one-cycle rdy strobe.
- Sits between the board pin (or transmitter loopback) and the consumer logic (display/FIFO).

---
 rtl/serial_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_serial_receiver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// UART-style receiver: 2-flop synchronizer, oversampled start/data/stop recovery,
// one-clk rdy/ferr strobes. Define SERIAL_RECEIVER_PARITY_EN to add an even-parity bit and perr.
module serial_receiver #(
    parameter int CLKFREQ    = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int D          = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rxd,
    output logic [D-1:0] data,
    output logic         rdy,
    output logic         ferr,
`ifdef SERIAL_RECEIVER_PARITY_EN
    output logic         perr,
`endif
    output logic         busy
);

    localparam int DIV = CLKFREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(D + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(D - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        WAITHI = 3'd5
    } state_t;

`ifdef SERIAL_RECEIVER_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    function automatic logic even_parity(input logic [D-1:0] v);
        return ^v;
    endfunction

    logic          sync1_q;
    logic          sync2_q;
    logic          rxs_s;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          tick_s;
    logic [SW-1:0] scount_q;
    logic [BW-1:0] bcount_q;
    logic [D-1:0]  shift_q;
    logic [D:0]    shift_ext_s;
    logic [D-1:0]  data_q;
    logic          rdy_q;
    logic          ferr_q;
    logic          busy_q;
    state_t        state_q;
`ifdef SERIAL_RECEIVER_PARITY_EN
    logic          par_q;
    logic          perr_q;
`endif

    // Divider next count and tick decode.
    always_comb begin
        tick_s      = (div_q == DIV_LAST);
        rxs_s       = sync2_q;
        shift_ext_s = {rxs_s, shift_q};
        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // Line synchronizer and free-running sample-tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            div_q   <= '0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            div_q   <= div_d;
        end
    end

    // Frame FSM with registered strobes; everything advances on sample ticks only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            scount_q <= '0;
            bcount_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            rdy_q  <= 1'b0;
            ferr_q <= 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
            perr_q <= 1'b0;
`endif
            if (tick_s) begin
                case (state_q)
                    IDLE: begin
                        if (!rxs_s) begin
                            state_q  <= START;
                            scount_q <= '0;
                            busy_q   <= 1'b1;
                        end
                    end
                    START: begin
                        if (scount_q == HALF_LAST) begin
                            scount_q <= '0;
                            bcount_q <= '0;
                            if (!rxs_s) begin
                                state_q <= DATA;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            scount_q <= scount_q + SW'(1);
                        end
                    end
                    DATA: begin
                        if (scount_q == FULL_LAST) begin
                            shift_q  <= shift_ext_s[D:1];
                            scount_q <= '0;
                            bcount_q <= bcount_q + BW'(1);
                            if (bcount_q == BIT_LAST) begin
                                state_q <= AFTER_DATA;
                            end
                        end else begin
                            scount_q <= scount_q + SW'(1);
                        end
                    end
`ifdef SERIAL_RECEIVER_PARITY_EN
                    PARITY: begin
                        if (scount_q == FULL_LAST) begin
                            par_q    <= rxs_s;
                            scount_q <= '0;
                            state_q  <= STOP;
                        end else begin
                            scount_q <= scount_q + SW'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (scount_q == FULL_LAST) begin
                            scount_q <= '0;
                            if (rxs_s) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
                                if (even_parity(shift_q) == par_q) begin
                                    data_q <= shift_q;
                                    rdy_q  <= 1'b1;
                                end else begin
                                    perr_q <= 1'b1;
                                end
`else
                                data_q <= shift_q;
                                rdy_q  <= 1'b1;
`endif
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= WAITHI;
                            end
                        end else begin
                            scount_q <= scount_q + SW'(1);
                        end
                    end
                    // A line held low after a bad stop must not look like a new start bit.
                    WAITHI: begin
                        if (rxs_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        scount_q <= '0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data = data_q;
    assign rdy  = rdy_q;
    assign ferr = ferr_q;
    assign busy = busy_q;
`ifdef SERIAL_RECEIVER_PARITY_EN
    assign perr = perr_q;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: directed frame table, glitch/reset corners,
// and random frames against a frame-level expectation model.
module tb_serial_receiver;

    localparam int CLKFREQ = 640_000;
    localparam int BAUD    = 10_000;
    localparam int OS      = 16;
    localparam int D       = 8;
    localparam int BIT     = CLKFREQ / BAUD;
`ifdef SERIAL_RECEIVER_PARITY_EN
    localparam int LAT_NOM = BIT * 21 / 2;
`else
    localparam int LAT_NOM = BIT * 19 / 2;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         rxd = 1'b1;
    logic [D-1:0] data;
    logic         rdy;
    logic         ferr;
    logic         busy;
`ifdef SERIAL_RECEIVER_PARITY_EN
    logic         perr;
`endif

    serial_receiver #(
        .CLKFREQ(CLKFREQ), .BAUD(BAUD), .D(D), .OVERSAMPLE(OS)
    ) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .data(data), .rdy(rdy), .ferr(ferr),
`ifdef SERIAL_RECEIVER_PARITY_EN
        .perr(perr),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    int  tot_rdy = 0;
    int  tot_ferr = 0;
    int  tot_perr = 0;
    int  tot_overlap = 0;
    time last_rdy_time = 0;
    time start_time = 0;
    int  base_rdy, base_ferr, base_perr;

    // Output monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rdy) begin
            tot_rdy++;
            last_rdy_time = $time;
        end
        if (ferr) tot_ferr++;
        if (rdy && ferr) tot_overlap++;
`ifdef SERIAL_RECEIVER_PARITY_EN
        if (perr) tot_perr++;
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic mark();
        base_rdy  = tot_rdy;
        base_ferr = tot_ferr;
        base_perr = tot_perr;
    endtask

    task automatic drive_bit(input logic b, input int len);
        @(posedge clk);
        #1 rxd = b;
        repeat (len - 1) @(posedge clk);
    endtask

    // Line-level frame: start, LSB-first data, optional parity, stop; line restored high after a bad stop.
    task automatic send_frame(input logic [D-1:0] b, input logic stop_b, input logic par_ok);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < D; i++) bits.push_back(b[i]);
`ifdef SERIAL_RECEIVER_PARITY_EN
        bits.push_back((^b) ^ ~par_ok);
`endif
        bits.push_back(stop_b);
        mark();
        for (int i = 0; i < bits.size(); i++) begin
            @(posedge clk);
            #1 rxd = bits[i];
            if (i == 0) start_time = $time;
            repeat (BIT - 1) @(posedge clk);
        end
        if (!stop_b) begin
            @(posedge clk);
            #1 rxd = 1'b1;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [D-1:0] byte_v;
        logic         stop_v;
        int           gap;
        logic [D-1:0] exp_data;
        int           exp_rdy;
        int           exp_ferr;
    } vec_t;

    vec_t         tbl[5];
    logic [D-1:0] last_good;
    logic [D-1:0] rb;
    logic         stop_ok, par_ok;
    int           gap, lat;
    int           e_rdy, e_ferr, e_perr;

    initial begin
        tbl[0] = '{byte_v: 8'hA5, stop_v: 1'b1, gap: 100, exp_data: 8'hA5, exp_rdy: 1, exp_ferr: 0};
        tbl[1] = '{byte_v: 8'h3C, stop_v: 1'b0, gap: 100, exp_data: 8'hA5, exp_rdy: 0, exp_ferr: 1};
        tbl[2] = '{byte_v: 8'h00, stop_v: 1'b1, gap: 0,   exp_data: 8'h00, exp_rdy: 1, exp_ferr: 0};
        tbl[3] = '{byte_v: 8'hFF, stop_v: 1'b1, gap: 100, exp_data: 8'hFF, exp_rdy: 1, exp_ferr: 0};
        tbl[4] = '{byte_v: 8'h81, stop_v: 1'b1, gap: 100, exp_data: 8'h81, exp_rdy: 1, exp_ferr: 0};

        repeat (3) @(negedge clk);
        check("reset_data", {24'h0, data}, 32'h0);
        check("reset_rdy", {31'h0, rdy}, 32'h0);
        check("reset_ferr", {31'h0, ferr}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].byte_v, tbl[i].stop_v, 1'b1);
            check($sformatf("tbl%0d_rdy", i), tot_rdy - base_rdy, tbl[i].exp_rdy);
            check($sformatf("tbl%0d_ferr", i), tot_ferr - base_ferr, tbl[i].exp_ferr);
            check($sformatf("tbl%0d_data", i), {24'h0, data}, {24'h0, tbl[i].exp_data});
            if (i == 0) begin
                lat = int'((last_rdy_time - start_time) / 10);
                check_range("tbl0_latency", lat, LAT_NOM - 8, LAT_NOM + 8);
            end
            if (!tbl[i].stop_v) begin
                check($sformatf("tbl%0d_busy_waithi", i), {31'h0, busy}, 32'h1);
                repeat (12) @(negedge clk);
                check($sformatf("tbl%0d_busy_released", i), {31'h0, busy}, 32'h0);
            end
            repeat (tbl[i].gap) @(posedge clk);
        end

        // Short low glitch on an idle line.
        mark();
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_busy_high", {31'h0, busy}, 32'h1);
        repeat (8) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy_low", {31'h0, busy}, 32'h0);
        check("glitch_rdy", tot_rdy - base_rdy, 32'h0);
        check("glitch_ferr", tot_ferr - base_ferr, 32'h0);

        // Reset in the middle of bit 4 of 0x81, then the line finishes that frame.
        rb = 8'h81;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(rb[i], BIT);
        drive_bit(rb[4], BIT / 2);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midreset_data%0d", i), {24'h0, data}, 32'h0);
            check($sformatf("midreset_busy%0d", i), {31'h0, busy}, 32'h0);
            check($sformatf("midreset_rdy%0d", i), {31'h0, rdy}, 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (BIT / 2 - 5) @(posedge clk);
        for (int i = 5; i < D; i++) drive_bit(rb[i], BIT);
        drive_bit(1'b1, BIT);
        repeat (20 * BIT) @(posedge clk);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("post_reset_rdy", tot_rdy - base_rdy, 32'h1);
        check("post_reset_data", {24'h0, data}, 32'h5A);
        check("post_reset_ferr", tot_ferr - base_ferr, 32'h0);
        last_good = 8'h5A;
        repeat (50) @(posedge clk);

`ifdef SERIAL_RECEIVER_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_rdy", tot_rdy - base_rdy, 32'h1);
        check("par_ok_perr", tot_perr - base_perr, 32'h0);
        check("par_ok_data", {24'h0, data}, 32'h07);
        repeat (50) @(posedge clk);
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_bad_rdy", tot_rdy - base_rdy, 32'h0);
        check("par_bad_perr", tot_perr - base_perr, 32'h1);
        last_good = 8'h07;
        repeat (50) @(posedge clk);
`endif

        // Random frames: good frames update data, bad stop reports ferr, bad parity reports perr.
        for (int n = 0; n < 16; n++) begin
            rb      = 8'($urandom);
            stop_ok = ($urandom_range(0, 4) != 0);
`ifdef SERIAL_RECEIVER_PARITY_EN
            par_ok  = ($urandom_range(0, 3) != 0);
`else
            par_ok  = 1'b1;
`endif
            gap = stop_ok ? $urandom_range(0, 80) : $urandom_range(16, 80);
            e_ferr = stop_ok ? 0 : 1;
            e_perr = (stop_ok && !par_ok) ? 1 : 0;
            e_rdy  = (stop_ok && par_ok) ? 1 : 0;
            if (e_rdy == 1) last_good = rb;
            send_frame(rb, stop_ok, par_ok);
            check($sformatf("rnd%0d_rdy", n), tot_rdy - base_rdy, e_rdy);
            check($sformatf("rnd%0d_ferr", n), tot_ferr - base_ferr, e_ferr);
            check($sformatf("rnd%0d_perr", n), tot_perr - base_perr, e_perr);
            check($sformatf("rnd%0d_data", n), {24'h0, data}, {24'h0, last_good});
            repeat (gap) @(posedge clk);
        end

        repeat (20) @(posedge clk);
        check("rdy_ferr_overlap", tot_overlap, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
